// File: rtl/nibble_fifo_pkg.sv
// nibble_fifo_pkg: shared constants, word type and pointer-width helper for nibble_fifo
package nibble_fifo_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  typedef logic [WIDTH_DEF-1:0] word_t;
  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/nibble_fifo_mem.sv
// nibble_fifo_mem: DEPTH-entry storage array, one write port, one registered read port
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i    read request and address
//   rdata_o         registered read data; holds when re_i is low, 0 after reset
import nibble_fifo_pkg::*;
module nibble_fifo_mem #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW = ptr_w(DEPTH_DEF) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // A read and a write to the same slot return the old word (full FIFO, simultaneous read/write).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/nibble_fifo.sv
// nibble_fifo: DEPTH-word buffer behind the 4-bit enable register with full/empty and sticky error flags
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   d, wr_en          write data and request
//   rd_en             read request; q updates the cycle after an accepted read
//   err_clr           synchronous clear of overflow/underflow (a same-cycle error wins)
//   q                 registered read data
//   full, empty       occupancy flags
//   overflow          sticky: write rejected while full
//   underflow         sticky: read rejected while empty
//   count             (only with NIBBLE_FIFO_COUNT_EN) occupancy, wp - rp
import nibble_fifo_pkg::*;
module nibble_fifo #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
`ifdef NIBBLE_FIFO_COUNT_EN
  , output logic [PW-1:0]  count
`endif
);
  localparam int AW = PW - 1;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic empty_q, empty_d, full_q, full_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wr_ok, rd_ok;
  always_comb begin
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    wr_ok = wr_en && (!full_q || rd_en);
    rd_ok = rd_en && !empty_q;
    wp_d = wr_ok ? wp_q + PW'(1) : wp_q;
    rp_d = rd_ok ? rp_q + PW'(1) : rp_q;
    // Flags are registered from next-state pointers so they match the pointer compare after each edge.
    empty_d = wp_d == rp_d;
    full_d = (wp_d[PW-1] != rp_d[PW-1]) && (wp_d[AW-1:0] == rp_d[AW-1:0]);
    ovf_d = (wr_en && full_q && !rd_en) || (ovf_q && !err_clr);
    unf_d = (rd_en && empty_q) || (unf_q && !err_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      empty_q <= empty_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  nibble_fifo_mem #(.WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (d),
    .re_i    (rd_ok),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (q)
  );
  assign full = full_q;
  assign empty = empty_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
`ifdef NIBBLE_FIFO_COUNT_EN
  assign count = wp_q - rp_q;
`endif
endmodule

// File: tb/tb_nibble_fifo.sv
// tb_nibble_fifo: directed table-driven bench for nibble_fifo (WIDTH=4, DEPTH=4)
module tb_nibble_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] d = 4'hA;
  logic wr_en = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [3:0] q;
  logic full, empty, overflow, underflow;
`ifdef NIBBLE_FIFO_COUNT_EN
  logic [2:0] count;
`endif
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  nibble_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .q         (q),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef NIBBLE_FIFO_COUNT_EN
    , .count   (count)
`endif
  );
  typedef struct {
    logic       r;
    logic [3:0] dd;
    logic       w, rd, c;
    logic [3:0] eq;
    logic       ef, ee, eo, eu;
  } vec_t;
  vec_t tbl [33];
  task automatic step(input logic r, input logic [3:0] dd, input logic w, input logic rd, input logic c);
    @(negedge clk);
    rst_n = r;
    d = dd;
    wr_en = w;
    rd_en = rd;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [3:0] eq, input logic ef, input logic ee,
                     input logic eo, input logic eu);
    n_vec++;
    if ({q, full, empty, overflow, underflow} !== {eq, ef, ee, eo, eu}) begin
      n_bad++;
      $display("FAIL %s: got q=%h full=%b empty=%b ovf=%b unf=%b, want q=%h full=%b empty=%b ovf=%b unf=%b",
               nm, q, full, empty, overflow, underflow, eq, ef, ee, eo, eu);
    end
  endtask
  task automatic chk_cnt(input int occ);
`ifdef NIBBLE_FIFO_COUNT_EN
    n_vec++;
    if (count !== 3'(occ)) begin
      n_bad++;
      $display("FAIL count: got %0d, want %0d", count, occ);
    end
`else
    if (occ < 0) $display("occupancy model went negative");
`endif
  endtask
  initial begin
    logic [3:0] exp_q;
    int occ;
    tbl = '{
      //  r  d     w  rd c   q     f  e  o  u
      '{0, 4'hA, 1, 0, 0, 4'h0, 0, 1, 0, 0},
      '{0, 4'hA, 1, 0, 0, 4'h0, 0, 1, 0, 0},
      '{1, 4'hA, 1, 0, 0, 4'h0, 0, 0, 0, 0},
      '{1, 4'hC, 1, 0, 0, 4'h0, 0, 0, 0, 0},
      '{1, 4'h6, 1, 0, 0, 4'h0, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'hA, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'hC, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'h6, 0, 1, 0, 0},
      '{1, 4'h8, 1, 1, 0, 4'h6, 0, 0, 0, 1},
      '{1, 4'h0, 0, 1, 0, 4'h8, 0, 1, 0, 1},
      '{1, 4'h0, 0, 0, 1, 4'h8, 0, 1, 0, 0},
      '{1, 4'h1, 1, 0, 0, 4'h8, 0, 0, 0, 0},
      '{1, 4'h2, 1, 0, 0, 4'h8, 0, 0, 0, 0},
      '{1, 4'h3, 1, 0, 0, 4'h8, 0, 0, 0, 0},
      '{1, 4'h4, 1, 0, 0, 4'h8, 1, 0, 0, 0},
      '{1, 4'hF, 1, 0, 0, 4'h8, 1, 0, 1, 0},
      '{1, 4'h0, 0, 1, 0, 4'h1, 0, 0, 1, 0},
      '{1, 4'h0, 0, 1, 0, 4'h2, 0, 0, 1, 0},
      '{1, 4'h0, 0, 1, 0, 4'h3, 0, 0, 1, 0},
      '{1, 4'h0, 0, 1, 0, 4'h4, 0, 1, 1, 0},
      '{1, 4'h0, 0, 1, 0, 4'h4, 0, 1, 1, 1},
      '{1, 4'h0, 0, 0, 1, 4'h4, 0, 1, 0, 0},
      '{1, 4'h5, 1, 0, 0, 4'h4, 0, 0, 0, 0},
      '{1, 4'h6, 1, 0, 0, 4'h4, 0, 0, 0, 0},
      '{1, 4'h7, 1, 0, 0, 4'h4, 0, 0, 0, 0},
      '{1, 4'h9, 1, 0, 0, 4'h4, 1, 0, 0, 0},
      '{1, 4'h1, 1, 1, 0, 4'h5, 1, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'h6, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'h7, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'h9, 0, 0, 0, 0},
      '{1, 4'h0, 0, 1, 0, 4'h1, 0, 1, 0, 0},
      '{1, 4'h0, 0, 1, 1, 4'h1, 0, 1, 0, 1},
      '{1, 4'h0, 0, 0, 1, 4'h1, 0, 1, 0, 0}
    };
    for (int i = 0; i < 33; i++) begin
      step(tbl[i].r, tbl[i].dd, tbl[i].w, tbl[i].rd, tbl[i].c);
      chk($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ef, tbl[i].ee, tbl[i].eo, tbl[i].eu);
    end
    step(1, 4'hB, 1, 0, 0);
    step(1, 4'hD, 1, 0, 0);
    step(1, 4'h0, 0, 1, 0);
    chk("pre_async_rst", 4'hB, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 4'h0, 0, 1, 0, 0);
    step(1, 4'h0, 0, 0, 0);
    chk("after_rst", 4'h0, 0, 1, 0, 0);
    chk_cnt(0);
    exp_q = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step(1, 4'(i + 3), 1, 0, 0);
      chk($sformatf("wrap_wr%0d", i), exp_q, 0, 0, 0, 0);
      chk_cnt(1);
      step(1, 4'h0, 0, 1, 0);
      exp_q = 4'(i + 3);
      chk($sformatf("wrap_rd%0d", i), exp_q, 0, 1, 0, 0);
      chk_cnt(0);
    end
    occ = 0;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, 4'(4 * j + k + 6), 1, 0, 0);
        occ++;
        chk($sformatf("fill%0d_%0d", j, k), exp_q, k == 3, 0, 0, 0);
        chk_cnt(occ);
      end
      for (int k = 0; k < 4; k++) begin
        step(1, 4'h0, 0, 1, 0);
        occ--;
        exp_q = 4'(4 * j + k + 6);
        chk($sformatf("drain%0d_%0d", j, k), exp_q, 0, k == 3, 0, 0);
        chk_cnt(occ);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
